// File: rtl/guess_scheduler.sv
// Round-robin turn scheduler sharing one hangman guess datapath between NUM_PLAYERS players.
// Optional idle-turn forfeit enabled by defining GUESS_SCHED_TIMEOUT_EN.
module guess_scheduler #(
    parameter int unsigned NUM_PLAYERS    = 2,
    parameter int unsigned SCORE_W        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_PLAYERS-1:0]         req,
    input  logic [5*NUM_PLAYERS-1:0]       char_in,
    output logic [NUM_PLAYERS-1:0]         ack,
    output logic [1:0]                     turn,
    output logic                           dp_valid,
    output logic [4:0]                     dp_char,
    input  logic                           dp_ready,
    input  logic                           dp_done,
    input  logic                           dp_hit,
    input  logic                           game_over,
    output logic [SCORE_W*NUM_PLAYERS-1:0] score,
    output logic                           timeout_flag,
    output logic                           busy
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitReq,
        StIssue,
        StWaitResult,
        StNext,
        StFinished
    } state_e;

    localparam logic [SCORE_W-1:0] ScoreMax   = '1;
    localparam logic [1:0]         LastPlayer = 2'(NUM_PLAYERS - 1);

    state_e                         r_state, w_state_d;
    logic [1:0]                     r_turn, w_turn_d;
    logic [NUM_PLAYERS-1:0]         r_ack, w_ack_d;
    logic                           r_dp_valid, w_dp_valid_d;
    logic [4:0]                     r_dp_char, w_dp_char_d;
    logic [SCORE_W*NUM_PLAYERS-1:0] r_score, w_score_d;
    logic                           r_tmo_flag, w_tmo_flag_d;
    logic                           r_busy, w_busy_d;

    logic                           w_req_cur;
    logic [4:0]                     w_char_cur;
    logic [SCORE_W-1:0]             w_score_cur;
    logic                           w_tmo_hit;

`ifdef GUESS_SCHED_TIMEOUT_EN
    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_tmo_cnt;

    // Counter is zero on every entry to WAIT_REQ because it clears whenever the state changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state == StWaitReq && w_state_d == StWaitReq) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign w_tmo_hit = (r_tmo_cnt == TmoLast);
`else
    logic [31:0] w_unused_tmo;
    assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
    assign w_tmo_hit    = 1'b0;
`endif

    // Current player's request, character and score, selected with constant indices.
    always_comb begin
        w_req_cur   = 1'b0;
        w_char_cur  = '0;
        w_score_cur = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (r_turn == 2'(i)) begin
                w_req_cur   = req[i];
                w_char_cur  = char_in[5*i +: 5];
                w_score_cur = r_score[SCORE_W*i +: SCORE_W];
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_turn_d     = r_turn;
        w_ack_d      = '0;
        w_dp_char_d  = r_dp_char;
        w_score_d    = r_score;
        w_tmo_flag_d = 1'b0;

        unique case (r_state)
            StIdle, StFinished: begin
                if (start) begin
                    w_score_d = '0;
                    w_turn_d  = '0;
                    w_state_d = StWaitReq;
                end
            end
            StWaitReq: begin
                if (game_over) begin
                    w_state_d = StFinished;
                end else if (w_req_cur) begin
                    w_dp_char_d = w_char_cur;
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        w_ack_d[i] = (r_turn == 2'(i));
                    end
                    w_state_d = StIssue;
                end else if (w_tmo_hit) begin
                    w_tmo_flag_d = 1'b1;
                    w_state_d    = StNext;
                end
            end
            StIssue: begin
                if (dp_ready) begin
                    w_state_d = StWaitResult;
                end
            end
            StWaitResult: begin
                if (dp_done) begin
                    if (dp_hit && w_score_cur != ScoreMax) begin
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            if (r_turn == 2'(i)) begin
                                w_score_d[SCORE_W*i +: SCORE_W] = w_score_cur + SCORE_W'(1);
                            end
                        end
                    end
                    if (game_over) begin
                        w_state_d = StFinished;
                    end else if (dp_hit) begin
                        w_state_d = StWaitReq;
                    end else begin
                        w_state_d = StNext;
                    end
                end
            end
            StNext: begin
                w_turn_d  = (r_turn == LastPlayer) ? 2'd0 : r_turn + 2'd1;
                w_state_d = StWaitReq;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        w_dp_valid_d = (w_state_d == StIssue);
        w_busy_d     = !(w_state_d inside {StIdle, StFinished});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_turn     <= '0;
            r_ack      <= '0;
            r_dp_valid <= 1'b0;
            r_dp_char  <= '0;
            r_score    <= '0;
            r_tmo_flag <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_turn     <= w_turn_d;
            r_ack      <= w_ack_d;
            r_dp_valid <= w_dp_valid_d;
            r_dp_char  <= w_dp_char_d;
            r_score    <= w_score_d;
            r_tmo_flag <= w_tmo_flag_d;
            r_busy     <= w_busy_d;
        end
    end

    assign ack          = r_ack;
    assign turn         = r_turn;
    assign dp_valid     = r_dp_valid;
    assign dp_char      = r_dp_char;
    assign score        = r_score;
    assign timeout_flag = r_tmo_flag;
    assign busy         = r_busy;

endmodule

// File: tb/tb_guess_scheduler.sv
// Directed bench for guess_scheduler: a phase-level model checked every cycle plus literal checks.
module tb_guess_scheduler;

    localparam int NP  = 3;
    localparam int SW  = 4;
    localparam int TMO = 8;
`ifdef GUESS_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int PH_IDLE = 0, PH_WREQ = 1, PH_ISSUE = 2, PH_WRES = 3, PH_NEXT = 4, PH_FIN = 5;
    localparam int SMAX = (1 << SW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [NP-1:0]   req = '0;
    logic [5*NP-1:0] char_in = '0;
    logic [NP-1:0]   ack;
    logic [1:0]      turn;
    logic            dp_valid;
    logic [4:0]      dp_char;
    logic            dp_ready = 1'b0;
    logic            dp_done = 1'b0;
    logic            dp_hit = 1'b0;
    logic            game_over = 1'b0;
    logic [SW*NP-1:0] score;
    logic            timeout_flag;
    logic            busy;

    int n_cmp = 0;
    int n_fail = 0;

    guess_scheduler #(
        .NUM_PLAYERS   (NP),
        .SCORE_W       (SW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .req         (req),
        .char_in     (char_in),
        .ack         (ack),
        .turn        (turn),
        .dp_valid    (dp_valid),
        .dp_char     (dp_char),
        .dp_ready    (dp_ready),
        .dp_done     (dp_done),
        .dp_hit      (dp_hit),
        .game_over   (game_over),
        .score       (score),
        .timeout_flag(timeout_flag),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: phase, whose turn, scores, and how long the current player has idled.
    int        m_ph = PH_IDLE;
    int        m_turn = 0;
    int        m_score[NP] = '{default: 0};
    int        m_wait = 0;
    logic [4:0]    m_char = '0;
    logic [NP-1:0] m_ack = '0;
    logic          m_tflag = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ph    <= PH_IDLE;
            m_turn  <= 0;
            for (int i = 0; i < NP; i++) m_score[i] <= 0;
            m_wait  <= 0;
            m_char  <= '0;
            m_ack   <= '0;
            m_tflag <= 1'b0;
        end else begin
            m_ack   <= '0;
            m_tflag <= 1'b0;
            case (m_ph)
                PH_IDLE, PH_FIN: begin
                    if (start) begin
                        for (int i = 0; i < NP; i++) m_score[i] <= 0;
                        m_turn <= 0;
                        m_wait <= 0;
                        m_ph   <= PH_WREQ;
                    end
                end
                PH_WREQ: begin
                    m_wait <= m_wait + 1;
                    if (game_over) begin
                        m_ph <= PH_FIN;
                    end else if (req[m_turn]) begin
                        m_char <= char_in[5*m_turn +: 5];
                        m_ack  <= NP'(1 << m_turn);
                        m_ph   <= PH_ISSUE;
                    end else if (TMO_EN && m_wait == TMO - 1) begin
                        m_tflag <= 1'b1;
                        m_ph    <= PH_NEXT;
                    end
                end
                PH_ISSUE: if (dp_ready) m_ph <= PH_WRES;
                PH_WRES: begin
                    if (dp_done) begin
                        if (dp_hit && m_score[m_turn] < SMAX) m_score[m_turn] <= m_score[m_turn] + 1;
                        m_wait <= 0;
                        m_ph   <= game_over ? PH_FIN : (dp_hit ? PH_WREQ : PH_NEXT);
                    end
                end
                PH_NEXT: begin
                    m_turn <= (m_turn + 1) % NP;
                    m_wait <= 0;
                    m_ph   <= PH_WREQ;
                end
                default: m_ph <= PH_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [SW*NP-1:0] sv;
        if (reset === 1'b1) begin
            for (int i = 0; i < NP; i++) sv[SW*i +: SW] = SW'(m_score[i]);
            check("mdl_ack", 32'(ack), 32'(m_ack));
            check("mdl_turn", 32'(turn), 32'(m_turn));
            check("mdl_valid", 32'(dp_valid), 32'(m_ph == PH_ISSUE));
            check("mdl_char", 32'(dp_char), 32'(m_char));
            check("mdl_score", 32'(score), 32'(sv));
            check("mdl_tflag", 32'(timeout_flag), 32'(m_tflag));
            check("mdl_busy", 32'(busy), 32'(m_ph != PH_IDLE && m_ph != PH_FIN));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full guess by player p; ends back in WAIT_REQ (or FINISHED when go is set).
    task automatic do_guess(input int p, input bit hit, input bit go);
        req = '0;
        req[p] = 1'b1;
        cyc(1);
        req = '0;
        dp_ready = 1'b1;
        cyc(1);
        dp_ready = 1'b0;
        dp_done = 1'b1;
        dp_hit = hit;
        game_over = go;
        cyc(1);
        dp_done = 1'b0;
        dp_hit = 1'b0;
        game_over = 1'b0;
        if (!hit && !go) cyc(1);
    endtask

    initial begin
        char_in = {5'd3, 5'd7, 5'b01101};
        #2 reset = 1'b0;
        cyc(2);
        check("rst_busy", 32'(busy), 0);
        check("rst_turn", 32'(turn), 0);
        check("rst_score", 32'(score), 0);
        check("rst_valid", 32'(dp_valid), 0);
        reset = 1'b1;

        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_turn", 32'(turn), 0);

        req = 3'b001;
        cyc(1);
        req = '0;
        check("first_ack", 32'(ack), 32'(3'b001));
        check("first_valid", 32'(dp_valid), 1);
        check("first_char", 32'(dp_char), 32'(5'b01101));
        for (int k = 1; k <= 3; k++) begin
            cyc(1);
            check("hold_ack", 32'(ack), 0);
            check("hold_valid", 32'(dp_valid), 1);
            check("hold_char", 32'(dp_char), 32'(5'b01101));
            if (k == 3) dp_ready = 1'b1;
        end
        cyc(1);
        dp_ready = 1'b0;
        check("valid_drop", 32'(dp_valid), 0);

        dp_done = 1'b1;
        dp_hit = 1'b1;
        cyc(1);
        dp_done = 1'b0;
        dp_hit = 1'b0;
        check("hit_score", 32'(score), 32'h001);
        check("hit_turn", 32'(turn), 0);

        req = 3'b001;
        cyc(1);
        req = '0;
        dp_ready = 1'b1;
        cyc(1);
        dp_ready = 1'b0;
        dp_done = 1'b1;
        cyc(1);
        dp_done = 1'b0;
        check("miss_turn_1cyc", 32'(turn), 0);
        cyc(1);
        check("miss_turn_2cyc", 32'(turn), 1);

        // Other players' requests and a stray dp_done are ignored in WAIT_REQ.
        req = 3'b101;
        dp_done = 1'b1;
        dp_hit = 1'b1;
        cyc(2);
        req = '0;
        dp_done = 1'b0;
        dp_hit = 1'b0;
        check("foreign_ack", 32'(ack), 0);
        check("foreign_valid", 32'(dp_valid), 0);
        check("foreign_score", 32'(score), 32'h001);

        do_guess(1, 1'b0, 1'b0);
        check("rr_turn2", 32'(turn), 2);
        do_guess(2, 1'b0, 1'b0);
        check("rr_wrap0", 32'(turn), 0);
        do_guess(0, 1'b0, 1'b0);
        check("rr_turn1", 32'(turn), 1);
        do_guess(1, 1'b0, 1'b0);
        do_guess(2, 1'b0, 1'b0);
        check("rr_back0", 32'(turn), 0);

        for (int k = 0; k < 16; k++) do_guess(0, 1'b1, 1'b0);
        check("sat_score", 32'(score), 32'h00F);
        check("sat_turn", 32'(turn), 0);

        do_guess(0, 1'b0, 1'b0);
        do_guess(1, 1'b1, 1'b1);
        check("fin_busy", 32'(busy), 0);
        check("fin_score", 32'(score), 32'h01F);
        check("fin_turn", 32'(turn), 1);
        dp_done = 1'b1;
        dp_hit = 1'b1;
        cyc(3);
        dp_done = 1'b0;
        dp_hit = 1'b0;
        check("fin_hold_score", 32'(score), 32'h01F);

        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("restart_score", 32'(score), 0);
        check("restart_turn", 32'(turn), 0);
        check("restart_busy", 32'(busy), 1);

        game_over = 1'b1;
        req = 3'b001;
        cyc(1);
        game_over = 1'b0;
        req = '0;
        check("go_prio_ack", 32'(ack), 0);
        check("go_prio_busy", 32'(busy), 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;

        if (TMO_EN) begin
            cyc(7);
            check("tmo_early", 32'(timeout_flag), 0);
            cyc(1);
            check("tmo_pulse", 32'(timeout_flag), 1);
            cyc(1);
            check("tmo_clear", 32'(timeout_flag), 0);
            check("tmo_turn", 32'(turn), 1);
            cyc(7);
            req = 3'b010;
            cyc(1);
            req = '0;
            check("tmo_req_ack", 32'(ack), 32'(3'b010));
            check("tmo_req_flag", 32'(timeout_flag), 0);
        end else begin
            cyc(20);
            check("notmo_turn", 32'(turn), 0);
            check("notmo_busy", 32'(busy), 1);
            req = 3'b001;
            cyc(1);
            req = '0;
            check("notmo_ack", 32'(ack), 32'(3'b001));
        end

        // Asynchronous reset while a guess is being issued.
        reset = 1'b0;
        #1;
        check("areset_valid", 32'(dp_valid), 0);
        check("areset_busy", 32'(busy), 0);
        check("areset_ack", 32'(ack), 0);
        check("areset_turn", 32'(turn), 0);
        cyc(1);
        reset = 1'b1;
        cyc(2);
        check("post_reset_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
